// File: rtl/wasm_mem_port_arbiter_pkg.sv
// Shared types for the wasm memory port arbiter.
//   mem_port_id_t      : requester index carried through the in-flight ID FIFO
//   MEM_ARB_MAX_PORTS  : upper bound on requester ports
//   arb_mode_e         : round-robin or fixed-priority arbitration
//   port_onehot        : one-hot strobe for a port index
//   next_port          : round-robin successor of a port index
package wasm_mem_port_arbiter_pkg;

    localparam int unsigned MEM_ARB_MAX_PORTS = 8;

    typedef logic [2:0] mem_port_id_t;

    typedef enum logic {
        ARB_ROUND_ROBIN = 1'b0,
        ARB_FIXED_PRIO  = 1'b1
    } arb_mode_e;

    function automatic logic [MEM_ARB_MAX_PORTS-1:0] port_onehot(input mem_port_id_t id);
        logic [MEM_ARB_MAX_PORTS-1:0] oh;
        oh     = '0;
        oh[id] = 1'b1;
        return oh;
    endfunction

    function automatic mem_port_id_t next_port(input mem_port_id_t id, input int unsigned n);
        return ({29'd0, id} == n - 32'd1) ? '0 : id + 3'd1;
    endfunction

endpackage

// File: rtl/wasm_mem_port_arbiter_if.sv
// Request/response bus bundle around the memory port arbiter.
//   up_req_*   : per-port requests (fields packed, port i at [i*W +: W])
//   up_resp_*  : one-hot response strobe with shared data/trap
//   m_req_*    : single forwarded request towards wasm_memory
//   m_resp_*   : in-order response from wasm_memory
// Modports: slave = the arbiter, master = the surrounding requesters + memory.
interface wasm_mem_port_arbiter_if #(
    parameter int unsigned NUM_PORTS = 3,
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned DATA_W    = 64
);

    logic [NUM_PORTS-1:0]        up_req_valid;
    logic [NUM_PORTS-1:0]        up_req_ready;
    logic [NUM_PORTS-1:0]        up_req_we;
    logic [NUM_PORTS*ADDR_W-1:0] up_req_addr;
    logic [NUM_PORTS*DATA_W-1:0] up_req_wdata;
    logic [NUM_PORTS*2-1:0]      up_req_size;
    logic [NUM_PORTS-1:0]        up_resp_valid;
    logic [DATA_W-1:0]           up_resp_rdata;
    logic                        up_resp_trap;

    logic                        m_req_valid;
    logic                        m_req_ready;
    logic                        m_req_we;
    logic [ADDR_W-1:0]           m_req_addr;
    logic [DATA_W-1:0]           m_req_wdata;
    logic [1:0]                  m_req_size;
    logic                        m_resp_valid;
    logic [DATA_W-1:0]           m_resp_rdata;
    logic                        m_resp_trap;

    modport slave (
        input  up_req_valid, up_req_we, up_req_addr, up_req_wdata, up_req_size,
        output up_req_ready, up_resp_valid, up_resp_rdata, up_resp_trap,
        output m_req_valid, m_req_we, m_req_addr, m_req_wdata, m_req_size,
        input  m_req_ready, m_resp_valid, m_resp_rdata, m_resp_trap
    );

    modport master (
        output up_req_valid, up_req_we, up_req_addr, up_req_wdata, up_req_size,
        input  up_req_ready, up_resp_valid, up_resp_rdata, up_resp_trap,
        input  m_req_valid, m_req_we, m_req_addr, m_req_wdata, m_req_size,
        output m_req_ready, m_resp_valid, m_resp_rdata, m_resp_trap
    );

endinterface

// File: rtl/wasm_mem_port_arbiter_id_fifo.sv
// wasm_id_fifo: small synchronous FIFO holding port IDs of in-flight requests.
//   clk_i, rst_ni : clock, async active-low reset (empties the FIFO)
//   push_i/data_i : enqueue (ignored when full)
//   pop_i/data_o  : dequeue head (ignored when empty); data_o shows the head
//   full_o, empty_o, count_o : occupancy, count_o in 0..DEPTH
module wasm_id_fifo #(
    parameter int unsigned WIDTH = 3,
    parameter int unsigned DEPTH = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   push_i,
    input  logic [WIDTH-1:0]       data_i,
    input  logic                   pop_i,
    output logic [WIDTH-1:0]       data_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] count_o
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign data_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

    // Explicit wrap keeps non-power-of-two depths correct.
    function automatic logic [PW-1:0] inc_ptr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = inc_ptr(wr_ptr_q);
        if (do_pop)  rd_ptr_d = inc_ptr(rd_ptr_q);
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: only entries below count are ever read as valid.
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/wasm_mem_port_arbiter.sv
// wasm_mem_port_arbiter: shares one wasm_memory request/response bus among
// NUM_PORTS requesters with up to MAX_OUTSTANDING in-order requests in flight.
//   clk, rst_n     : clock, async active-low reset
//   bus (slave)    : up_req_* / up_resp_* requester side, m_req_* / m_resp_* memory side
//   outstanding_o  : number of requests in flight (0..MAX_OUTSTANDING)
//   err_orphan_o   : sticky, a response arrived with nothing in flight
module wasm_mem_port_arbiter
    import wasm_mem_port_arbiter_pkg::*;
#(
    parameter int unsigned NUM_PORTS       = 3,
    parameter int unsigned ADDR_W          = 32,
    parameter int unsigned DATA_W          = 64,
    parameter int unsigned MAX_OUTSTANDING = 4,
    parameter int unsigned FIXED_PRIO      = 0
) (
    input  logic                             clk,
    input  logic                             rst_n,
    wasm_mem_port_arbiter_if.slave           bus,
    output logic [$clog2(MAX_OUTSTANDING):0] outstanding_o,
    output logic                             err_orphan_o
);

    localparam arb_mode_e ARB_MODE = (FIXED_PRIO != 0) ? ARB_FIXED_PRIO : ARB_ROUND_ROBIN;

    mem_port_id_t rr_ptr_q, rr_ptr_d;
    logic         hold_q, hold_d;
    mem_port_id_t hold_id_q, hold_id_d;
    logic         err_orphan_q, err_orphan_d;

    mem_port_id_t grant;
    logic         found;
    int unsigned  rr_idx;
    logic         any_valid, can_issue, req_valid, issue, resp_fire;

    logic                         fifo_full, fifo_empty;
    mem_port_id_t                 fifo_head;
    logic [$clog2(MAX_OUTSTANDING):0] fifo_count;

    // Per-port fields padded to MEM_ARB_MAX_PORTS so a 3-bit grant indexes cleanly.
    logic [MEM_ARB_MAX_PORTS-1:0] valid_ext;
    logic                         we_a    [MEM_ARB_MAX_PORTS];
    logic [ADDR_W-1:0]            addr_a  [MEM_ARB_MAX_PORTS];
    logic [DATA_W-1:0]            wdata_a [MEM_ARB_MAX_PORTS];
    logic [1:0]                   size_a  [MEM_ARB_MAX_PORTS];

    assign valid_ext = MEM_ARB_MAX_PORTS'(bus.up_req_valid);

    for (genvar g = 0; g < MEM_ARB_MAX_PORTS; g++) begin : g_unpack
        if (g < NUM_PORTS) begin : g_live
            assign we_a[g]    = bus.up_req_we[g];
            assign addr_a[g]  = bus.up_req_addr[g*ADDR_W +: ADDR_W];
            assign wdata_a[g] = bus.up_req_wdata[g*DATA_W +: DATA_W];
            assign size_a[g]  = bus.up_req_size[g*2 +: 2];
        end else begin : g_pad
            assign we_a[g]    = 1'b0;
            assign addr_a[g]  = '0;
            assign wdata_a[g] = '0;
            assign size_a[g]  = '0;
        end
    end

    // Grant: a port left waiting by a stalled memory keeps the grant; otherwise
    // fixed priority (lowest index) or first valid at/after rr_ptr, wrapping.
    always_comb begin
        grant  = '0;
        found  = 1'b0;
        rr_idx = '0;
        if (hold_q && valid_ext[hold_id_q]) begin
            grant = hold_id_q;
            found = 1'b1;
        end else if (ARB_MODE == ARB_FIXED_PRIO) begin
            for (int unsigned i = 0; i < NUM_PORTS; i++) begin
                if (!found && valid_ext[mem_port_id_t'(i)]) begin
                    grant = mem_port_id_t'(i);
                    found = 1'b1;
                end
            end
        end else begin
            for (int unsigned off = 0; off < NUM_PORTS; off++) begin
                rr_idx = {29'd0, rr_ptr_q} + off;
                if (rr_idx >= NUM_PORTS) rr_idx = rr_idx - NUM_PORTS;
                if (!found && valid_ext[mem_port_id_t'(rr_idx)]) begin
                    grant = mem_port_id_t'(rr_idx);
                    found = 1'b1;
                end
            end
        end
    end

    // Issue depends only on registered occupancy, so a same-cycle response
    // never frees a slot combinationally.
    assign any_valid = |bus.up_req_valid;
    assign can_issue = !fifo_full;
    assign req_valid = rst_n && any_valid && can_issue;
    assign issue     = req_valid && bus.m_req_ready;
    assign resp_fire = bus.m_resp_valid && !fifo_empty;

    assign bus.m_req_valid   = req_valid;
    assign bus.m_req_we      = rst_n ? we_a[grant]    : 1'b0;
    assign bus.m_req_addr    = rst_n ? addr_a[grant]  : '0;
    assign bus.m_req_wdata   = rst_n ? wdata_a[grant] : '0;
    assign bus.m_req_size    = rst_n ? size_a[grant]  : '0;
    assign bus.up_req_ready  = issue ? NUM_PORTS'(port_onehot(grant)) : '0;

    assign bus.up_resp_valid = resp_fire ? NUM_PORTS'(port_onehot(fifo_head)) : '0;
    assign bus.up_resp_rdata = rst_n ? bus.m_resp_rdata : '0;
    assign bus.up_resp_trap  = resp_fire && bus.m_resp_trap;

    assign outstanding_o = fifo_count;
    assign err_orphan_o  = err_orphan_q;

    wasm_id_fifo #(
        .WIDTH ($bits(mem_port_id_t)),
        .DEPTH (MAX_OUTSTANDING)
    ) u_id_fifo (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .push_i  (issue),
        .data_i  (grant),
        .pop_i   (bus.m_resp_valid),
        .data_o  (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    always_comb begin
        rr_ptr_d     = rr_ptr_q;
        hold_d       = req_valid && !bus.m_req_ready;
        hold_id_d    = grant;
        err_orphan_d = err_orphan_q || (bus.m_resp_valid && fifo_empty);
        if (issue && (ARB_MODE == ARB_ROUND_ROBIN)) rr_ptr_d = next_port(grant, NUM_PORTS);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q     <= '0;
            hold_q       <= 1'b0;
            hold_id_q    <= '0;
            err_orphan_q <= 1'b0;
        end else begin
            rr_ptr_q     <= rr_ptr_d;
            hold_q       <= hold_d;
            hold_id_q    <= hold_id_d;
            err_orphan_q <= err_orphan_d;
        end
    end

endmodule

// File: tb/tb_wasm_mem_port_arbiter.sv
// Bench for wasm_mem_port_arbiter: a round-robin instance checked every cycle
// against a queue-based reference model, a fixed-priority instance checked by
// hand-computed expectations, directed scenarios plus randomized traffic.
module tb_wasm_mem_port_arbiter;
    import wasm_mem_port_arbiter_pkg::*;

    localparam int unsigned NP = 3;
    localparam int unsigned AW = 32;
    localparam int unsigned DW = 64;
    localparam int unsigned MO = 4;
    localparam int unsigned OW = $clog2(MO) + 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    wasm_mem_port_arbiter_if #(.NUM_PORTS(NP), .ADDR_W(AW), .DATA_W(DW)) bus_rr ();
    wasm_mem_port_arbiter_if #(.NUM_PORTS(NP), .ADDR_W(AW), .DATA_W(DW)) bus_fp ();

    logic [OW-1:0] outst_rr, outst_fp;
    logic          orphan_rr, orphan_fp;

    wasm_mem_port_arbiter #(
        .NUM_PORTS(NP), .ADDR_W(AW), .DATA_W(DW), .MAX_OUTSTANDING(MO), .FIXED_PRIO(0)
    ) u_rr (
        .clk(clk), .rst_n(rst_n), .bus(bus_rr), .outstanding_o(outst_rr), .err_orphan_o(orphan_rr)
    );

    wasm_mem_port_arbiter #(
        .NUM_PORTS(NP), .ADDR_W(AW), .DATA_W(DW), .MAX_OUTSTANDING(MO), .FIXED_PRIO(1)
    ) u_fp (
        .clk(clk), .rst_n(rst_n), .bus(bus_fp), .outstanding_o(outst_fp), .err_orphan_o(orphan_fp)
    );

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_port(input int i, input logic we, input logic [AW-1:0] a,
                            input logic [DW-1:0] wd, input logic [1:0] sz);
        bus_rr.up_req_we[i]              = we;
        bus_rr.up_req_addr[i*AW +: AW]   = a;
        bus_rr.up_req_wdata[i*DW +: DW]  = wd;
        bus_rr.up_req_size[i*2 +: 2]     = sz;
    endtask

    // ---------------- reference model (round-robin instance) ----------------
    int  m_rr;
    int  m_hold;
    int  m_q[$];
    bit  m_orphan;

    initial begin
        logic [NP-1:0] v;
        int  g, p;
        bit  exp_mv, exp_issue, popping;
        m_rr = 0; m_hold = -1; m_orphan = 0;
        forever begin
            @(negedge clk);
            #1;
            if (!rst_n) begin
                chk("rst m_req_valid",   bus_rr.m_req_valid,   0);
                chk("rst m_req_we",      bus_rr.m_req_we,      0);
                chk("rst m_req_addr",    bus_rr.m_req_addr,    0);
                chk("rst m_req_wdata",   bus_rr.m_req_wdata,   0);
                chk("rst m_req_size",    bus_rr.m_req_size,    0);
                chk("rst up_req_ready",  bus_rr.up_req_ready,  0);
                chk("rst up_resp_valid", bus_rr.up_resp_valid, 0);
                chk("rst up_resp_rdata", bus_rr.up_resp_rdata, 0);
                chk("rst up_resp_trap",  bus_rr.up_resp_trap,  0);
                chk("rst outstanding",   outst_rr,             0);
                chk("rst err_orphan",    orphan_rr,            0);
                m_q.delete(); m_rr = 0; m_hold = -1; m_orphan = 0;
            end else begin
                v = bus_rr.up_req_valid;
                g = -1;
                if (m_hold >= 0 && v[m_hold]) g = m_hold;
                else begin
                    for (int k = 0; k < NP; k++) begin
                        p = (m_rr + k) % NP;
                        if (g < 0 && v[p]) g = p;
                    end
                end
                exp_mv    = (v != '0) && (m_q.size() < MO);
                exp_issue = exp_mv && bus_rr.m_req_ready;
                popping   = bus_rr.m_resp_valid && (m_q.size() > 0);
                chk("m_req_valid", bus_rr.m_req_valid, exp_mv);
                if (exp_mv) begin
                    chk("m_req_we",    bus_rr.m_req_we,    bus_rr.up_req_we[g]);
                    chk("m_req_addr",  bus_rr.m_req_addr,  bus_rr.up_req_addr[g*AW +: AW]);
                    chk("m_req_wdata", bus_rr.m_req_wdata, bus_rr.up_req_wdata[g*DW +: DW]);
                    chk("m_req_size",  bus_rr.m_req_size,  bus_rr.up_req_size[g*2 +: 2]);
                end
                chk("up_req_ready", bus_rr.up_req_ready, exp_issue ? (64'd1 << g) : 64'd0);
                chk("up_resp_valid", bus_rr.up_resp_valid, popping ? (64'd1 << m_q[0]) : 64'd0);
                if (popping) begin
                    chk("up_resp_rdata", bus_rr.up_resp_rdata, bus_rr.m_resp_rdata);
                    chk("up_resp_trap",  bus_rr.up_resp_trap,  bus_rr.m_resp_trap);
                end
                chk("outstanding", outst_rr, m_q.size());
                chk("err_orphan",  orphan_rr, m_orphan);
                // advance to the state after the coming rising edge
                if (popping) void'(m_q.pop_front());
                else if (bus_rr.m_resp_valid) m_orphan = 1;
                if (exp_issue) begin
                    m_q.push_back(g);
                    m_rr = (g + 1) % NP;
                end
                m_hold = (exp_mv && !bus_rr.m_req_ready) ? g : -1;
            end
        end
    end

    // ---------------- fixed-priority instance: hand-computed grants ----------------
    initial begin
        bus_fp.up_req_valid = '0;
        bus_fp.up_req_we    = '0;
        bus_fp.up_req_wdata = '0;
        bus_fp.up_req_size  = '0;
        bus_fp.up_req_addr  = {32'h300, 32'h200, 32'h100};
        bus_fp.m_req_ready  = 1'b1;
        bus_fp.m_resp_valid = 1'b0;
        bus_fp.m_resp_rdata = '0;
        bus_fp.m_resp_trap  = 1'b0;
        wait (rst_n);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            bus_fp.up_req_valid = 3'b101;
            #2;
            chk("fp addr prio", bus_fp.m_req_addr, 32'h100);
            chk("fp ready prio", bus_fp.up_req_ready, 3'b001);
        end
        @(negedge clk);
        bus_fp.up_req_valid = 3'b100;
        #2;
        chk("fp addr port2", bus_fp.m_req_addr, 32'h300);
        chk("fp ready port2", bus_fp.up_req_ready, 3'b100);
        @(negedge clk);
        bus_fp.up_req_valid = '0;
        #2;
        chk("fp outstanding", outst_fp, 4);
    end

    // ---------------- directed scenarios + randomized traffic ----------------
    logic [AW-1:0] t1_addr [4] = '{32'h10, 32'h20, 32'h30, 32'h10};
    logic [NP-1:0] t1_rdy  [4] = '{3'b001, 3'b010, 3'b100, 3'b001};
    logic [NP-1:0] t1_resp [4] = '{3'b010, 3'b100, 3'b001, 3'b010};

    bit            pend [NP];
    int            mem_pending;

    initial begin
        bus_rr.up_req_valid = '0;
        bus_rr.up_req_we    = '0;
        bus_rr.up_req_addr  = '0;
        bus_rr.up_req_wdata = '0;
        bus_rr.up_req_size  = '0;
        bus_rr.m_req_ready  = 1'b1;
        bus_rr.m_resp_valid = 1'b0;
        bus_rr.m_resp_rdata = '0;
        bus_rr.m_resp_trap  = 1'b0;
        set_port(0, 1'b0, 32'h10, 64'h0, 2'd3);
        set_port(1, 1'b0, 32'h20, 64'h0, 2'd3);
        set_port(2, 1'b0, 32'h30, 64'h0, 2'd3);
        bus_rr.up_req_valid = 3'b111;   // requests held during reset must not leak out

        // 1: round-robin over three continuous readers, then fill and drain
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            #2;
            chk("t1 grant addr", bus_rr.m_req_addr, t1_addr[c]);
            chk("t1 grant ready", bus_rr.up_req_ready, t1_rdy[c]);
            @(negedge clk);
        end
        #2;
        chk("t4 full count", outst_rr, 4);
        chk("t4 full blocks", bus_rr.m_req_valid, 0);
        @(negedge clk);
        bus_rr.up_req_valid = 3'b010;
        bus_rr.m_resp_valid = 1'b1;
        bus_rr.m_resp_rdata = 64'h1111_2222_3333_4444;
        #2;
        chk("t1 first resp", bus_rr.up_resp_valid, 3'b001);
        chk("t1 resp data", bus_rr.up_resp_rdata, 64'h1111_2222_3333_4444);
        chk("t4 pop no bypass", bus_rr.m_req_valid, 0);
        @(negedge clk);
        bus_rr.m_resp_valid = 1'b0;
        #2;
        chk("t4 count after pop", outst_rr, 3);
        chk("t4 issue resumes", bus_rr.m_req_addr, 32'h20);
        chk("t4 issue ready", bus_rr.up_req_ready, 3'b010);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            bus_rr.up_req_valid = '0;
            bus_rr.m_resp_valid = 1'b1;
            bus_rr.m_resp_rdata = 64'(c);
            #2;
            chk("t1 resp order", bus_rr.up_resp_valid, t1_resp[c]);
        end
        @(negedge clk);
        bus_rr.m_resp_valid = 1'b0;
        #2;
        chk("t1 drained", outst_rr, 0);

        // 3: stalled memory, port 1 keeps the grant even when port 2 joins
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            bus_rr.up_req_valid = (c == 0) ? 3'b010 : 3'b110;
            bus_rr.m_req_ready  = 1'b0;
            #2;
            chk("t3 held addr", bus_rr.m_req_addr, 32'h20);
            chk("t3 no ready", bus_rr.up_req_ready, 0);
        end
        @(negedge clk);
        bus_rr.m_req_ready = 1'b1;
        #2;
        chk("t3 held addr", bus_rr.m_req_addr, 32'h20);
        chk("t3 ready pulse", bus_rr.up_req_ready, 3'b010);
        @(negedge clk);
        bus_rr.up_req_valid = 3'b100;
        #2;
        chk("t3 next grant", bus_rr.m_req_addr, 32'h30);
        chk("t3 next ready", bus_rr.up_req_ready, 3'b100);
        @(negedge clk);
        bus_rr.up_req_valid = '0;
        bus_rr.m_resp_valid = 1'b1;
        @(negedge clk);
        @(negedge clk);
        bus_rr.m_resp_valid = 1'b0;
        #2;
        chk("t3 drained", outst_rr, 0);

        // 5: orphan response
        @(negedge clk);
        bus_rr.m_resp_valid = 1'b1;
        #2;
        chk("t5 orphan dropped", bus_rr.up_resp_valid, 0);
        @(negedge clk);
        bus_rr.m_resp_valid = 1'b0;
        #2;
        chk("t5 orphan set", orphan_rr, 1);
        repeat (3) @(negedge clk);
        #2;
        chk("t5 orphan sticky", orphan_rr, 1);

        // 6: trapped write response, then reset with two in flight
        set_port(2, 1'b1, 32'h40, 64'hDEAD_BEEF, 2'd2);
        @(negedge clk);
        bus_rr.up_req_valid = 3'b100;
        #2;
        chk("t6 write we", bus_rr.m_req_we, 1);
        chk("t6 write ready", bus_rr.up_req_ready, 3'b100);
        @(negedge clk);
        bus_rr.up_req_valid = '0;
        bus_rr.m_resp_valid = 1'b1;
        bus_rr.m_resp_trap  = 1'b1;
        #2;
        chk("t6 trap strobe", bus_rr.up_resp_valid, 3'b100);
        chk("t6 trap flag", bus_rr.up_resp_trap, 1);
        @(negedge clk);
        bus_rr.m_resp_valid = 1'b0;
        bus_rr.m_resp_trap  = 1'b0;
        bus_rr.up_req_valid = 3'b001;
        @(negedge clk);
        @(negedge clk);
        bus_rr.up_req_valid = '0;
        #2;
        chk("t6 two in flight", outst_rr, 2);
        @(negedge clk);
        bus_rr.up_req_valid = 3'b001;
        rst_n = 1'b0;
        #2;
        chk("t6 reset count", outst_rr, 0);
        chk("t6 reset gates req", bus_rr.m_req_valid, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        bus_rr.up_req_valid = '0;
        #2;
        chk("t6 after reset count", outst_rr, 0);
        chk("t6 after reset orphan", orphan_rr, 0);

        // randomized traffic obeying the hold-until-ready protocol
        mem_pending = 0;
        for (int i = 0; i < NP; i++) pend[i] = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            for (int i = 0; i < NP; i++) begin
                if (!pend[i] && $urandom_range(0, 2) != 0) begin
                    pend[i] = 1;
                    set_port(i, 1'($urandom_range(0, 1)), $urandom,
                             {$urandom, $urandom}, 2'($urandom_range(0, 3)));
                end
                bus_rr.up_req_valid[i] = pend[i];
            end
            bus_rr.m_req_ready  = ($urandom_range(0, 9) < 7);
            bus_rr.m_resp_valid = (mem_pending > 0) &&
                                  ($urandom_range(0, 99) < ((cyc < 1500) ? 30 : 70));
            bus_rr.m_resp_rdata = {$urandom, $urandom};
            bus_rr.m_resp_trap  = ($urandom_range(0, 7) == 0);
            #2;
            for (int i = 0; i < NP; i++) if (bus_rr.up_req_ready[i]) pend[i] = 0;
            if (bus_rr.m_resp_valid) mem_pending--;
            if (bus_rr.m_req_valid && bus_rr.m_req_ready) mem_pending++;
        end

        // drain, bounded
        for (int cyc = 0; cyc < 50 && mem_pending > 0; cyc++) begin
            @(negedge clk);
            bus_rr.up_req_valid = '0;
            bus_rr.m_resp_valid = 1'b1;
            #2;
            mem_pending--;
        end
        @(negedge clk);
        bus_rr.up_req_valid = '0;
        bus_rr.m_resp_valid = 1'b0;
        #2;
        chk("final drained", outst_rr, 0);
        chk("final no orphan", orphan_rr, 0);
        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #500000;
        n_errors++;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $fatal(1, "watchdog expired");
    end

endmodule
